branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 80 ++++++++
 tb/tb_branch_predictor.sv | 137 +++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters and resolve statistics
module branch_predictor #(
   parameter int ENTRIES  = 16,
   parameter int IDX_NBIT = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_is_branch,
   input  logic        upd_is_jump,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispred
);
   localparam int TAG_NBIT = 30 - IDX_NBIT;
   logic [ENTRIES-1:0]  valid;
   logic [TAG_NBIT-1:0] tags    [ENTRIES];
   logic [31:0]         targets [ENTRIES];
   logic [1:0]          ctrs    [ENTRIES];
   logic [IDX_NBIT-1:0] if_idx, upd_idx;
   logic                upd_hit, qual, eff_taken, mispred, wr;
   logic [1:0]          cur_ctr, new_ctr;
   logic [31:0]         new_target;
   logic                unused;
   assign unused  = ^{if_pc[1:0], upd_pc[1:0]};
   assign if_idx  = if_pc[IDX_NBIT+1:2];
   assign upd_idx = upd_pc[IDX_NBIT+1:2];
   // fetch lookup: predict redirect only on a tag hit with a taken-leaning counter
   always_comb begin
      pred_taken  = valid[if_idx] && tags[if_idx] == if_pc[31:IDX_NBIT+2] && ctrs[if_idx][1];
      pred_target = pred_taken ? targets[if_idx] : if_pc + 32'd4;
   end
   // resolve-side decode: jumps dominate branches and are always taken
   always_comb begin
      upd_hit    = valid[upd_idx] && tags[upd_idx] == upd_pc[31:IDX_NBIT+2];
      qual       = upd_en && (upd_is_branch || upd_is_jump);
      eff_taken  = upd_is_jump || upd_taken;
      mispred    = (upd_pred_taken != eff_taken) || (eff_taken && upd_pred_target != upd_target);
      wr         = qual && (upd_is_jump || upd_hit || upd_taken);
      cur_ctr    = ctrs[upd_idx];
      new_ctr    = upd_is_jump ? 2'b11 :
                   !upd_hit    ? 2'b10 :
                   upd_taken   ? (cur_ctr == 2'b11 ? 2'b11 : cur_ctr + 2'd1) :
                                 (cur_ctr == 2'b00 ? 2'b00 : cur_ctr - 2'd1);
      new_target = eff_taken ? upd_target : targets[upd_idx];
   end
   // BTB entry write; a not-taken branch miss leaves the table untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tags[i]    <= '0;
            targets[i] <= '0;
            ctrs[i]    <= 2'b00;
         end
      end else if (wr) begin
         valid[upd_idx]   <= 1'b1;
         tags[upd_idx]    <= upd_pc[31:IDX_NBIT+2];
         targets[upd_idx] <= new_target;
         ctrs[upd_idx]    <= new_ctr;
      end
   end
   // resolve statistics, wrapping modulo 2^32
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else if (qual) begin
         stat_branches <= stat_branches + 32'd1;
         stat_mispred  <= stat_mispred + {31'd0, mispred};
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor
module tb_branch_predictor;
   logic        clk, rst, pred_taken, upd_en, upd_is_branch, upd_is_jump, upd_taken, upd_pred_taken;
   logic [31:0] if_pc, pred_target, upd_pc, upd_target, upd_pred_target, stat_branches, stat_mispred;
   int total = 0;
   int bad   = 0;

   branch_predictor dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch), .upd_is_jump(upd_is_jump),
      .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
      if_pc = pc;
      #1;
      chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, pt});
      chk({tag, "_target"}, pred_target, tgt);
   endtask

   task automatic stats(input string tag, input logic [31:0] br, input logic [31:0] mp);
      chk({tag, "_branches"}, stat_branches, br);
      chk({tag, "_mispred"}, stat_mispred, mp);
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
      upd_pc = pc; upd_is_branch = br; upd_is_jump = jmp; upd_taken = tk;
      upd_target = tgt; upd_pred_taken = pt; upd_pred_target = ptg; upd_en = 1'b1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                      input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
      set_upd(pc, br, jmp, tk, tgt, pt, ptg);
      @(posedge clk);
      #1;
      upd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; upd_en = 1'b0; if_pc = '0;
      set_upd('0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      upd_en = 1'b0;
      #12 rst = 1'b0;
      look("rst", 32'h0040_0010, 1'b0, 32'h0040_0014);
      stats("rst", 0, 0);
      // first taken branch allocates with ctr=10
      upd(32'h0040_0010, 1, 0, 1, 32'h0040_0000, 0, 32'h0040_0014);
      look("alloc", 32'h0040_0010, 1'b1, 32'h0040_0000);
      stats("alloc", 1, 1);
      upd(32'h0040_0010, 1, 0, 0, 32'h0040_0000, 1, 32'h0040_0000);
      look("nt1", 32'h0040_0010, 1'b0, 32'h0040_0014);
      stats("nt1", 2, 2);
      // saturate up: 01 -> 10 -> 11 -> 11
      upd(32'h0040_0010, 1, 0, 1, 32'h0040_0000, 0, 32'h0040_0014);
      upd(32'h0040_0010, 1, 0, 1, 32'h0040_0000, 1, 32'h0040_0000);
      upd(32'h0040_0010, 1, 0, 1, 32'h0040_0000, 1, 32'h0040_0000);
      look("sat_up", 32'h0040_0010, 1'b1, 32'h0040_0000);
      stats("sat_up", 5, 3);
      upd(32'h0040_0010, 1, 0, 0, 32'h0040_0000, 1, 32'h0040_0000);
      look("ctr10", 32'h0040_0010, 1'b1, 32'h0040_0000);
      upd(32'h0040_0010, 1, 0, 0, 32'h0040_0000, 1, 32'h0040_0000);
      look("ctr01", 32'h0040_0010, 1'b0, 32'h0040_0014);
      upd(32'h0040_0010, 1, 0, 0, 32'h0040_0000, 0, 32'h0040_0014);
      upd(32'h0040_0010, 1, 0, 0, 32'h0040_0000, 0, 32'h0040_0014);
      look("sat_dn", 32'h0040_0010, 1'b0, 32'h0040_0014);
      stats("sat_dn", 9, 5);
      // a hit from 00 goes to 01 (still not taken); a wrongly invalidated entry would reallocate at 10
      upd(32'h0040_0010, 1, 0, 1, 32'h0040_0000, 0, 32'h0040_0014);
      look("still_valid", 32'h0040_0010, 1'b0, 32'h0040_0014);
      upd(32'h0040_0010, 1, 0, 1, 32'h0040_0000, 0, 32'h0040_0014);
      look("retrain", 32'h0040_0010, 1'b1, 32'h0040_0000);
      stats("retrain", 11, 7);
      // aliasing on index 4
      look("alias_look", 32'h0040_0050, 1'b0, 32'h0040_0054);
      upd(32'h0040_0050, 1, 0, 0, 32'h0040_0800, 0, 32'h0040_0054);
      look("alias_nt_keep", 32'h0040_0010, 1'b1, 32'h0040_0000);
      stats("alias_nt", 12, 7);
      upd(32'h0040_0050, 1, 0, 1, 32'h0040_0800, 0, 32'h0040_0054);
      look("alias_evicted", 32'h0040_0010, 1'b0, 32'h0040_0014);
      look("alias_new", 32'h0040_0050, 1'b1, 32'h0040_0800);
      stats("alias_t", 13, 8);
      // jump with upd_taken=0 is still taken, ctr=11
      upd(32'h0040_0100, 0, 1, 0, 32'h0040_0200, 0, 32'h0040_0104);
      look("jump", 32'h0040_0100, 1'b1, 32'h0040_0200);
      stats("jump", 14, 9);
      upd(32'h0040_0100, 0, 1, 1, 32'h0040_0300, 1, 32'h0040_0200);
      look("jr", 32'h0040_0100, 1'b1, 32'h0040_0300);
      stats("jr", 15, 10);
      // both flags: treated as a correctly predicted jump
      upd(32'h0040_0104, 1, 1, 0, 32'h0040_0400, 1, 32'h0040_0400);
      look("both", 32'h0040_0104, 1'b1, 32'h0040_0400);
      stats("both", 16, 10);
      // upd_en without a flag does nothing
      upd(32'h0040_0108, 0, 0, 1, 32'h0040_0500, 0, 32'h0040_010c);
      look("noflag", 32'h0040_0108, 1'b0, 32'h0040_010c);
      stats("noflag", 16, 10);
      // same-cycle lookup sees pre-edge contents
      set_upd(32'h0040_0108, 0, 1, 1, 32'h0040_0600, 0, 32'h0040_010c);
      look("same_pre", 32'h0040_0108, 1'b0, 32'h0040_010c);
      @(posedge clk);
      #1;
      upd_en = 1'b0;
      look("same_post", 32'h0040_0108, 1'b1, 32'h0040_0600);
      stats("same", 17, 11);
      // async reset between edges with a pending update
      set_upd(32'h0040_0100, 0, 1, 1, 32'h0040_0900, 0, 32'h0040_0104);
      if_pc = 32'h0040_0100;
      #2 rst = 1'b1;
      look("arst", 32'h0040_0100, 1'b0, 32'h0040_0104);
      stats("arst", 0, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      upd_en = 1'b0;
      look("arst_rel", 32'h0040_0100, 1'b0, 32'h0040_0104);
      stats("arst_rel", 0, 0);
      @(posedge clk);
      #1;
      look("arst_after", 32'h0040_0100, 1'b0, 32'h0040_0104);
      stats("arst_after", 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
